mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-port synchronous memory (unified I/D BRAM, 1-cycle read latency) between two requesters: instruction fetch (IF) and data memory access (DM).
- Sits between the fetch and memory-access pipeline stages and the memory macro.
- A denied requester sees ready low and must hold its request; the pipeline controller stalls on req & ~ready.
- DM has fixed priority, bounded by an anti-starvation counter for IF.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both requesters.
- DATA_WIDTH, 32, data word width (multiple of 8).
- STARVE_LIMIT, 4, consecutive IF denials after which IF wins one cycle; 0 = strict DM priority.

Ports:
- sysclk  in  1  clock
- cpu_resetn  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_flush  in  1  squash any in-flight fetch read
- if_ready  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- dm_req  in  1  data request
- dm_we  in  1  1 = write, 0 = read
- dm_be  in  DATA_WIDTH/8  write byte enables
- dm_addr  in  ADDR_WIDTH  data byte address
- dm_wdata  in  DATA_WIDTH  write data
- dm_ready  out  1  data granted this cycle
- dm_rvalid  out  1  data read data valid
- dm_rdata  out  DATA_WIDTH  data read data
- mem_en  out  1  memory enable
- mem_we  out  DATA_WIDTH/8  memory byte write enables
- mem_addr  out  ADDR_WIDTH-2  memory word address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read enable

Behaviour:
- The clock is sysclk. Reset cpu_resetn is asynchronous and active-low. All state is cleared on reset assertion: if_rvalid=0, dm_rvalid=0, starvation counter=0, return-owner=NONE.

Grant (combinational, same cycle):
- grant_if = if_req & (~dm_req | starve_hit).
- grant_dm = dm_req & ~grant_if.
- starve_hit = (STARVE_LIMIT != 0) & (cnt == STARVE_LIMIT).
- if_ready = grant_if; dm_ready = grant_dm. At most one grant per cycle.

Memory drive:
- mem_en = grant_if | grant_dm.
- mem_addr = granted address [ADDR_WIDTH-1:2]. Low 2 bits are ignored with no misalignment check.
- mem_we = dm_be when grant_dm & dm_we, else 0. IF never writes.
- mem_wdata = dm_wdata when grant_dm, else 0.
- With no grant, all mem_* are 0.

Starvation counter:
- Width $clog2(STARVE_LIMIT+1). Increments when if_req & ~grant_if. Saturates at STARVE_LIMIT.
- Clears to 0 when grant_if or when ~if_req.

Read return (registered owner):
- On a clock edge with a granted read, owner <= IF or DM; otherwise owner <= NONE.
- if_rvalid = (owner==IF), dm_rvalid = (owner==DM), both registered. A granted write produces no rvalid.
- if_rdata and dm_rdata both pass mem_rdata through. rvalid is the only qualifier.
- Latency: request granted in cycle N, data valid in cycle N+1. Back-to-back grants are allowed, giving one access per cycle at full throughput.

Flush and reset edge cases:
- If if_flush=1 in cycle N+1, the IF return data is still presented but if_rvalid is forced to 0 that cycle.
- If if_flush=1 in cycle N together with a new IF grant, that new read is NOT squashed: flush applies only to reads already in flight.
- Reset mid-read: the in-flight read is dropped, and no rvalid is issued after reset deasserts.

Test Plan:
- Reset with if_req=1, dm_req=0, if_addr=0x100 -> if_ready=1, mem_addr=0x40, mem_en=1. Next cycle mem_rdata=0xDEADBEEF gives if_rvalid=1, if_rdata=0xDEADBEEF, dm_rvalid=0.
- if_req and dm_req held high continuously, dm_we=0, STARVE_LIMIT=4 -> dm_ready for 4 cycles, if_ready on the 5th, then the pattern repeats (4 DM : 1 IF). Each rvalid goes to the matching owner one cycle later.
- dm_req=1, dm_we=1, dm_be=4'b0011, dm_addr=0x204, dm_wdata=0x12345678 -> mem_we=4'b0011, mem_addr=0x81, mem_wdata=0x12345678. No dm_rvalid the following cycle.
- IF read granted in cycle N, if_flush=1 in cycle N+1 -> if_rvalid=0 in N+1. A second IF grant issued with if_flush=1 in N+1 -> if_rvalid=1 in N+2.
- IF read granted, then cpu_resetn pulsed low mid-cycle before the next edge -> if_rvalid goes 0 immediately (asynchronously), stays 0 after release, and the counter reads 0.
- STARVE_LIMIT=0 with both requests held for 10 cycles -> dm_ready=1 every cycle and if_ready is never asserted.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the IF/DM memory port arbiter: both requester channels plus the memory macro pins.
// A requester asserts *_req and holds request fields stable until it sees *_ready high in the same cycle; read data returns one cycle later with *_rvalid.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    if_req;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic                    if_flush;
  logic                    if_ready;
  logic                    if_rvalid;
  logic [DATA_WIDTH-1:0]   if_rdata;

  logic                    dm_req;
  logic                    dm_we;
  logic [DATA_WIDTH/8-1:0] dm_be;
  logic [ADDR_WIDTH-1:0]   dm_addr;
  logic [DATA_WIDTH-1:0]   dm_wdata;
  logic                    dm_ready;
  logic                    dm_rvalid;
  logic [DATA_WIDTH-1:0]   dm_rdata;

  logic                    mem_en;
  logic [DATA_WIDTH/8-1:0] mem_we;
  logic [ADDR_WIDTH-3:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_ready, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_ready, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_ready, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_ready, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 1-cycle-latency BRAM between instruction fetch and data access.
// DM wins by default; IF is guaranteed one grant after STARVE_LIMIT consecutive denials.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 sysclk,
  input  logic                 cpu_resetn,
  mem_port_arbiter_if.slave    bus,
  output logic [31:0]          dbg_starve_cnt_o,
  output logic [1:0]           dbg_owner_o
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starve_hit;
  logic             grant_if;
  logic             grant_dm;
  logic             unused_addr_lsbs;

  // Byte-offset bits are deliberately dropped: the memory is word addressed.
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.dm_addr[1:0]};

  assign starve_hit = (STARVE_LIMIT != 0) && (cnt_q == CNT_W'(STARVE_LIMIT));
  assign grant_if   = bus.if_req && (!bus.dm_req || starve_hit);
  assign grant_dm   = bus.dm_req && !grant_if;

  assign bus.if_ready = grant_if;
  assign bus.dm_ready = grant_dm;

  always_comb begin
    bus.mem_en    = grant_if || grant_dm;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant_if) begin
      bus.mem_addr = bus.if_addr[ADDR_WIDTH-1:2];
    end else if (grant_dm) begin
      bus.mem_addr  = bus.dm_addr[ADDR_WIDTH-1:2];
      bus.mem_wdata = bus.dm_wdata;
      if (bus.dm_we) begin
        bus.mem_we = bus.dm_be;
      end
    end
  end

  // Counts consecutive IF denials; any IF grant or idle IF restarts the window.
  always_comb begin
    cnt_d = '0;
    if (bus.if_req && !grant_if) begin
      cnt_d = (cnt_q == CNT_W'(STARVE_LIMIT)) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Return-owner state: who receives mem_rdata on the following cycle.
  always_ff @(posedge sysclk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (grant_if) begin
      owner_d = OWN_IF;
    end else if (grant_dm && !bus.dm_we) begin
      owner_d = OWN_DM;
    end
  end

  // Flush only masks a fetch already in flight; a fetch granted alongside it proceeds.
  always_comb begin
    bus.if_rvalid = (owner_q == OWN_IF) && !bus.if_flush;
    bus.dm_rvalid = (owner_q == OWN_DM);
    bus.if_rdata  = bus.mem_rdata;
    bus.dm_rdata  = bus.mem_rdata;
  end

  assign dbg_starve_cnt_o = 32'(cnt_q);
  assign dbg_owner_o      = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a behavioural BRAM drives mem_rdata, a reference model predicts grants and returns.
// A second instance with STARVE_LIMIT=0 shares the stimulus to cover strict DM priority.
module tb_mem_port_arbiter;

  logic sysclk;
  logic cpu_resetn;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

  logic [31:0] dbg_cnt_a, dbg_cnt_b;
  logic [1:0]  unused_owner_a, unused_owner_b;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut_a (
    .sysclk           (sysclk),
    .cpu_resetn       (cpu_resetn),
    .bus              (bus_a.slave),
    .dbg_starve_cnt_o (dbg_cnt_a),
    .dbg_owner_o      (unused_owner_a)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(0)) dut_b (
    .sysclk           (sysclk),
    .cpu_resetn       (cpu_resetn),
    .bus              (bus_b.slave),
    .dbg_starve_cnt_o (dbg_cnt_b),
    .dbg_owner_o      (unused_owner_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // ---------------- behavioural BRAM ----------------
  logic [31:0] bram [256];
  logic [31:0] bram_q;

  function automatic logic [31:0] init_word(input int i);
    return (i == 64) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  always @(posedge sysclk) begin
    if (!cpu_resetn) begin
      for (int i = 0; i < 256; i++) bram[i] <= init_word(i);
      bram_q <= '0;
    end else if (bus_a.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus_a.mem_we[b]) bram[bus_a.mem_addr[7:0]][8*b +: 8] <= bus_a.mem_wdata[8*b +: 8];
      bram_q <= bram[bus_a.mem_addr[7:0]];
    end
  end

  assign bus_a.mem_rdata = bram_q;
  assign bus_b.mem_rdata = bram_q;
  assign bus_b.if_req    = bus_a.if_req;
  assign bus_b.if_addr   = bus_a.if_addr;
  assign bus_b.if_flush  = bus_a.if_flush;
  assign bus_b.dm_req    = bus_a.dm_req;
  assign bus_b.dm_we     = bus_a.dm_we;
  assign bus_b.dm_be     = bus_a.dm_be;
  assign bus_b.dm_addr   = bus_a.dm_addr;
  assign bus_b.dm_wdata  = bus_a.dm_wdata;

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_mem [256];
  int          denied_a = 0;        // consecutive IF denials, saturating at 4
  logic        pend_if_a = 0, pend_dm_a = 0, pend_if_b = 0, pend_dm_b = 0;
  logic [31:0] exp_q[$];            // read data expected on the next return of dut_a

  logic        r_if_req, r_if_flush, r_dm_req, r_dm_we;
  logic [31:0] r_if_addr, r_dm_addr, r_dm_wdata;
  logic [3:0]  r_dm_be;

  logic        obs_if_ready_a, obs_if_rvalid_a, obs_dm_rvalid_a;
  logic        obs_if_ready_b, obs_dm_ready_b;
  logic [3:0]  obs_mem_we;
  logic [29:0] obs_mem_addr;
  logic [31:0] obs_mem_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    r_if_req = 0; r_if_flush = 0; r_if_addr = '0;
    r_dm_req = 0; r_dm_we = 0; r_dm_be = '0; r_dm_addr = '0; r_dm_wdata = '0;
  endtask

  // Entered just after a rising edge; drives one cycle, checks at the falling edge, advances the model.
  task automatic step();
    logic        gif, gdm, gif_b, gdm_b, exp_ifv;
    logic [31:0] exp_data;
    logic [29:0] exp_addr;
    bus_a.if_req   = r_if_req;
    bus_a.if_addr  = r_if_addr;
    bus_a.if_flush = r_if_flush;
    bus_a.dm_req   = r_dm_req;
    bus_a.dm_we    = r_dm_we;
    bus_a.dm_be    = r_dm_be;
    bus_a.dm_addr  = r_dm_addr;
    bus_a.dm_wdata = r_dm_wdata;
    @(negedge sysclk);

    gif   = r_if_req && (!r_dm_req || denied_a == 4);
    gdm   = r_dm_req && !gif;
    gif_b = r_if_req && !r_dm_req;
    gdm_b = r_dm_req;
    exp_addr = gif ? r_if_addr[31:2] : (gdm ? r_dm_addr[31:2] : 30'd0);

    check("if_ready", bus_a.if_ready, gif);
    check("dm_ready", bus_a.dm_ready, gdm);
    check("mem_en", bus_a.mem_en, gif || gdm);
    check("mem_addr", bus_a.mem_addr, exp_addr);
    check("mem_we", bus_a.mem_we, (gdm && r_dm_we) ? r_dm_be : 4'd0);
    check("mem_wdata", bus_a.mem_wdata, gdm ? r_dm_wdata : 32'd0);
    check("starve_cnt", dbg_cnt_a, denied_a);

    exp_ifv = pend_if_a && !r_if_flush;
    check("if_rvalid", bus_a.if_rvalid, exp_ifv);
    check("dm_rvalid", bus_a.dm_rvalid, pend_dm_a);
    if (pend_if_a || pend_dm_a) begin
      exp_data = exp_q.pop_front();
      if (exp_ifv)   check("if_rdata", bus_a.if_rdata, exp_data);
      if (pend_dm_a) check("dm_rdata", bus_a.dm_rdata, exp_data);
    end

    check("b_if_ready", bus_b.if_ready, gif_b);
    check("b_dm_ready", bus_b.dm_ready, gdm_b);
    check("b_if_rvalid", bus_b.if_rvalid, pend_if_b && !r_if_flush);
    check("b_dm_rvalid", bus_b.dm_rvalid, pend_dm_b);
    check("b_starve_cnt", dbg_cnt_b, 0);

    obs_if_ready_a  = bus_a.if_ready;
    obs_if_rvalid_a = bus_a.if_rvalid;
    obs_dm_rvalid_a = bus_a.dm_rvalid;
    obs_if_ready_b  = bus_b.if_ready;
    obs_dm_ready_b  = bus_b.dm_ready;
    obs_mem_we      = bus_a.mem_we;
    obs_mem_addr    = bus_a.mem_addr;
    obs_mem_wdata   = bus_a.mem_wdata;

    pend_if_a = gif;
    pend_dm_a = gdm && !r_dm_we;
    if (gif) exp_q.push_back(ref_mem[r_if_addr[9:2]]);
    if (gdm && !r_dm_we) exp_q.push_back(ref_mem[r_dm_addr[9:2]]);
    if (gdm && r_dm_we)
      for (int b = 0; b < 4; b++)
        if (r_dm_be[b]) ref_mem[r_dm_addr[9:2]][8*b +: 8] = r_dm_wdata[8*b +: 8];
    denied_a = (r_if_req && !gif) ? ((denied_a < 4) ? denied_a + 1 : 4) : 0;
    pend_if_b = gif_b;
    pend_dm_b = gdm_b && !r_dm_we;

    @(posedge sysclk);
    #1;
  endtask

  // Pulses reset low and high again inside one cycle, entered just after a rising edge.
  task automatic reset_mid();
    set_idle();
    bus_a.if_req = 0; bus_a.dm_req = 0; bus_a.if_flush = 0;
    #1;
    check("pre_rst_if_rvalid", bus_a.if_rvalid, pend_if_a);
    check("pre_rst_dm_rvalid", bus_a.dm_rvalid, pend_dm_a);
    check("pre_rst_cnt", dbg_cnt_a, denied_a);
    cpu_resetn = 0;
    #1;
    check("rst_if_rvalid", bus_a.if_rvalid, 1'b0);
    check("rst_dm_rvalid", bus_a.dm_rvalid, 1'b0);
    check("rst_cnt", dbg_cnt_a, 0);
    check("rst_b_dm_rvalid", bus_b.dm_rvalid, 1'b0);
    pend_if_a = 0; pend_dm_a = 0; pend_if_b = 0; pend_dm_b = 0;
    denied_a = 0;
    exp_q.delete();
    cpu_resetn = 1;
    #1;
    check("rel_if_rvalid", bus_a.if_rvalid, 1'b0);
    check("rel_dm_rvalid", bus_a.dm_rvalid, 1'b0);
    @(posedge sysclk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    set_idle();
    bus_a.if_req = 0; bus_a.if_addr = '0; bus_a.if_flush = 0;
    bus_a.dm_req = 0; bus_a.dm_we = 0; bus_a.dm_be = '0; bus_a.dm_addr = '0; bus_a.dm_wdata = '0;
    cpu_resetn = 0;
    #3;
    check("reset_if_rvalid", bus_a.if_rvalid, 1'b0);
    check("reset_dm_rvalid", bus_a.dm_rvalid, 1'b0);
    check("reset_cnt", dbg_cnt_a, 0);
    #9 cpu_resetn = 1;
    @(posedge sysclk);
    #1;

    // First fetch after reset: 0x100 -> word 0x40 holding 0xDEADBEEF.
    set_idle(); r_if_req = 1; r_if_addr = 32'h100;
    step();
    check("first_if_ready", obs_if_ready_a, 1'b1);
    check("first_mem_addr", obs_mem_addr, 30'h40);
    set_idle();
    step();
    check("first_if_rvalid", obs_if_rvalid_a, 1'b1);
    check("first_dm_rvalid", obs_dm_rvalid_a, 1'b0);

    // Byte-enabled write, then no return, then read back the merged word.
    set_idle(); r_dm_req = 1; r_dm_we = 1; r_dm_be = 4'b0011;
    r_dm_addr = 32'h204; r_dm_wdata = 32'h12345678;
    step();
    check("wr_mem_we", obs_mem_we, 4'b0011);
    check("wr_mem_addr", obs_mem_addr, 30'h81);
    check("wr_mem_wdata", obs_mem_wdata, 32'h12345678);
    set_idle(); r_dm_req = 1; r_dm_addr = 32'h204;
    step();
    check("wr_no_rvalid", obs_dm_rvalid_a, 1'b0);
    set_idle();
    step();

    // Both requesters held: 4 DM grants then 1 IF grant, repeating; strict instance never grants IF.
    for (int i = 0; i < 10; i++) begin
      set_idle(); r_if_req = 1; r_dm_req = 1;
      r_if_addr = 32'($urandom_range(0, 1023)); r_dm_addr = 32'($urandom_range(0, 1023));
      step();
      check("starve_pattern", obs_if_ready_a, (i % 5) == 4);
      check("strict_if_ready", obs_if_ready_b, 1'b0);
      check("strict_dm_ready", obs_dm_ready_b, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      set_idle(); r_if_req = 1; r_dm_req = 1; r_dm_addr = 32'($urandom_range(0, 1023));
      step();
    end
    reset_mid();
    set_idle();
    step();

    // Flush squashes the in-flight fetch but not one granted in the flush cycle.
    set_idle(); r_if_req = 1; r_if_addr = 32'h100;
    step();
    set_idle(); r_if_req = 1; r_if_addr = 32'h104; r_if_flush = 1;
    step();
    check("flush_squash", obs_if_rvalid_a, 1'b0);
    set_idle();
    step();
    check("flush_new_kept", obs_if_rvalid_a, 1'b1);

    // Reset pulsed while a fetch return is pending.
    set_idle(); r_if_req = 1; r_if_addr = 32'h100;
    step();
    reset_mid();
    set_idle();
    step();
    check("post_rst_if_rvalid", obs_if_rvalid_a, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r_if_req   = ($urandom_range(0, 3) != 0);
      r_if_addr  = 32'($urandom_range(0, 1023));
      r_if_flush = ($urandom_range(0, 7) == 0);
      r_dm_req   = ($urandom_range(0, 2) != 0);
      r_dm_we    = ($urandom_range(0, 2) == 0);
      r_dm_be    = 4'($urandom_range(0, 15));
      r_dm_addr  = 32'($urandom_range(0, 1023));
      r_dm_wdata = $urandom;
      step();
    end
    set_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
